// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice.
// Holds the opcode and funct3 constants, the ALU operation encoding and the
// packed control bundle that travels D -> E -> M -> W.
package pipe_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BYTE = 3'b000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_t;

  // mem_to_reg doubles as the "this is a load" flag used by the interlock.
  typedef struct packed {
    logic    reg_write;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    imm_i;
    logic    byte_sel;
    alu_op_t alu_op;
    logic [4:0] rd;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder.
// Ports:
//   instr  in  32        instruction in the decode stage
//   ctrl   out ctrl_t    decoded control bundle; all-zero for anything that
//                        is not a supported instruction or writes x0
module ctrl_decode
  import pipe_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       unused_rs;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign rd        = instr[11:7];
  // Source register fields only matter to the hazard check in the top.
  assign unused_rs = ^instr[24:15];

  always_comb begin
    // NOTE: every field gets a default before the case so no path can infer a latch.
    ctrl = CTRL_NOP;
    case (opcode)
      OP_LOAD: begin
        if (funct3 == F3_WORD || funct3 == F3_BYTE) begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.alu_src    = 1'b1;
          ctrl.imm_i      = 1'b1;
          ctrl.byte_sel   = (funct3 == F3_BYTE);
        end
      end
      OP_STORE: begin
        if (funct3 == F3_WORD || funct3 == F3_BYTE) begin
          ctrl.mem_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.byte_sel  = (funct3 == F3_BYTE);
        end
      end
      OP_R: begin
        ctrl.reg_write = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: ctrl.alu_op = ALU_ADD;
          10'b0100000_000: ctrl.alu_op = ALU_SUB;
          10'b0000000_111: ctrl.alu_op = ALU_AND;
          10'b0000000_110: ctrl.alu_op = ALU_OR;
          10'b0000000_100: ctrl.alu_op = ALU_XOR;
          10'b0000000_010: ctrl.alu_op = ALU_SLT;
          default:         ctrl.reg_write = 1'b0;
        endcase
      end
      OP_I: begin
        if (funct3 == 3'b000) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.imm_i     = 1'b1;
        end
      end
      default: ctrl = CTRL_NOP;
    endcase

    // A register write to x0 has no architectural effect: collapse to a NOP.
    if (ctrl.reg_write) begin
      if (rd == 5'd0) ctrl = CTRL_NOP;
      else            ctrl.rd = rd;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: decode, E/M/W control registers and optional load-use
// interlock. Build with PIPE_CTRL_INTERLOCK_EN defined to enable the
// interlock; without it bubbleE is tied low and hazards never stall.
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   instrD              instruction in decode
//   dhit                memory ready; 0 freezes every stage
//   pc_en               fetch advance enable
//   LoadD, ByteD        decode-stage immediate / byte selects
//   ALUSrcE, AluControlE execute-stage operand select and ALU op
//   MemWriteM           memory-stage store strobe
//   RegWriteW, MemtoRegW, ByteW  writeback controls
//   bubbleE             execute register loads a NOP at the next edge
module pipe_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrD,
  input  logic        dhit,
  output logic        pc_en,
  output logic        LoadD,
  output logic        ByteD,
  output logic        ALUSrcE,
  output logic [2:0]  AluControlE,
  output logic        MemWriteM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        ByteW,
  output logic        bubbleE
);

  ctrl_t ctrl_d, ctrl_e, ctrl_m, ctrl_w;
  logic  hazard;
  logic  unused_w;

  ctrl_decode u_decode (
    .instr (instrD),
    .ctrl  (ctrl_d)
  );

`ifdef PIPE_CTRL_INTERLOCK_EN
  // Load in E whose result a decode-stage source needs. Both source fields
  // are compared regardless of format, so a false match only costs a cycle.
  assign hazard = ctrl_e.mem_to_reg && (ctrl_e.rd != 5'd0) &&
                  ((ctrl_e.rd == instrD[19:15]) || (ctrl_e.rd == instrD[24:20]));
`else
  assign hazard = 1'b0;
`endif

  assign pc_en   = dhit & ~hazard & ~reset;
  assign bubbleE = dhit & hazard & ~reset;

  always_ff @(posedge clk) begin
    // NOTE: reset is tested first so it clears the stages even during a memory stall.
    if (reset) begin
      ctrl_e <= CTRL_NOP;
      ctrl_m <= CTRL_NOP;
      ctrl_w <= CTRL_NOP;
    end else if (dhit) begin
      ctrl_e <= hazard ? CTRL_NOP : ctrl_d;
      ctrl_m <= ctrl_e;
      ctrl_w <= ctrl_m;
    end
  end

  assign LoadD       = ctrl_d.imm_i;
  assign ByteD       = ctrl_d.byte_sel;
  assign ALUSrcE     = ctrl_e.alu_src;
  assign AluControlE = ctrl_e.alu_op;
  assign MemWriteM   = ctrl_m.mem_write;
  assign RegWriteW   = ctrl_w.reg_write;
  assign MemtoRegW   = ctrl_w.mem_to_reg;
  // Byte select in writeback only means something for loads.
  assign ByteW       = ctrl_w.byte_sel & ctrl_w.mem_to_reg;

  // Writeback keeps the whole bundle (including rd) although only a few bits drive ports.
  assign unused_w    = ^ctrl_w;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. The reference model tracks the raw
// instruction word held in each stage and derives every output from the
// instruction-set rules, so it is independent of the RTL's bundle encoding.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrD;
  logic        dhit;
  logic        pc_en, LoadD, ByteD, ALUSrcE, MemWriteM;
  logic        RegWriteW, MemtoRegW, ByteW, bubbleE;
  logic [2:0]  AluControlE;

  int checks   = 0;
  int failures = 0;

`ifdef PIPE_CTRL_INTERLOCK_EN
  localparam bit INTERLOCK = 1'b1;
`else
  localparam bit INTERLOCK = 1'b0;
`endif

  localparam logic [31:0] I_LW   = 32'h0040A283; // lw   x5,4(x1)
  localparam logic [31:0] I_ADD  = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] I_SB   = 32'h00218023; // sb   x2,0(x3)
  localparam logic [31:0] I_SW   = 32'h0040A423; // sw   x4,8(x1)
  localparam logic [31:0] I_ADDI = 32'h00100013; // addi x0,x0,1
  localparam logic [31:0] I_ZERO = 32'h00000000;

  pipe_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .instrD      (instrD),
    .dhit        (dhit),
    .pc_en       (pc_en),
    .LoadD       (LoadD),
    .ByteD       (ByteD),
    .ALUSrcE     (ALUSrcE),
    .AluControlE (AluControlE),
    .MemWriteM   (MemWriteM),
    .RegWriteW   (RegWriteW),
    .MemtoRegW   (MemtoRegW),
    .ByteW       (ByteW),
    .bubbleE     (bubbleE)
  );

  always #5 clk = ~clk;

  // Model state: the instruction word occupying each stage (0 = bubble).
  logic [31:0] w_e, w_m, w_w;

  typedef struct packed {
    bit       ld;
    bit       st;
    bit       wr;
    bit       imm_i;
    bit       alu_src;
    bit       byt;
    bit [2:0] alu;
    bit [4:0] rd;
  } info_t;

  function automatic info_t info(input logic [31:0] w);
    info_t      r  = '0;
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    logic [4:0] rd = w[11:7];
    if (op == 7'h03 && (f3 == 3'd2 || f3 == 3'd0)) begin
      r.ld = 1; r.wr = 1; r.imm_i = 1; r.alu_src = 1; r.byt = (f3 == 3'd0);
    end else if (op == 7'h23 && (f3 == 3'd2 || f3 == 3'd0)) begin
      r.st = 1; r.alu_src = 1; r.byt = (f3 == 3'd0);
    end else if (op == 7'h33) begin
      r.wr = 1;
      if      (f7 == 7'h00 && f3 == 3'd0) r.alu = 3'd0;
      else if (f7 == 7'h20 && f3 == 3'd0) r.alu = 3'd1;
      else if (f7 == 7'h00 && f3 == 3'd7) r.alu = 3'd2;
      else if (f7 == 7'h00 && f3 == 3'd6) r.alu = 3'd3;
      else if (f7 == 7'h00 && f3 == 3'd4) r.alu = 3'd4;
      else if (f7 == 7'h00 && f3 == 3'd2) r.alu = 3'd5;
      else r.wr = 0;
    end else if (op == 7'h13 && f3 == 3'd0) begin
      r.wr = 1; r.imm_i = 1; r.alu_src = 1;
    end
    if (r.wr) begin
      if (rd == 5'd0) r = '0;
      else            r.rd = rd;
    end
    return r;
  endfunction

  function automatic bit model_hazard();
    info_t e = info(w_e);
    return INTERLOCK && e.ld && (e.rd == instrD[19:15] || e.rd == instrD[24:20]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    info_t d  = info(instrD);
    info_t e  = info(w_e);
    info_t m  = info(w_m);
    info_t wb = info(w_w);
    bit    hz = model_hazard();
    chk("pc_en",       32'(pc_en),       32'(dhit & ~hz & ~reset));
    chk("bubbleE",     32'(bubbleE),     32'(dhit & hz & ~reset));
    chk("LoadD",       32'(LoadD),       32'(d.imm_i));
    chk("ByteD",       32'(ByteD),       32'(d.byt));
    chk("ALUSrcE",     32'(ALUSrcE),     32'(e.alu_src));
    chk("AluControlE", 32'(AluControlE), 32'(e.alu));
    chk("MemWriteM",   32'(MemWriteM),   32'(m.st));
    chk("RegWriteW",   32'(RegWriteW),   32'(wb.wr));
    chk("MemtoRegW",   32'(MemtoRegW),   32'(wb.ld));
    chk("ByteW",       32'(ByteW),       32'(wb.ld & wb.byt));
  endtask

  // One clock: apply inputs, check mid-cycle, advance model on the edge.
  // adv reports the DUT's pc_en so the bench's fetch follows the real stall.
  task automatic cycle(input logic [31:0] ins, input logic d, input logic r, output bit adv);
    bit hz;
    instrD = ins;
    dhit   = d;
    reset  = r;
    #3;
    check_all();
    adv = (pc_en === 1'b1);
    hz  = model_hazard();
    @(posedge clk);
    if (r) begin
      w_e = '0; w_m = '0; w_w = '0;
    end else if (d) begin
      w_w = w_m;
      w_m = w_e;
      w_e = hz ? 32'h0 : ins;
    end
    #1;
  endtask

  // Present an instruction until fetch accepts it (bounded).
  task automatic feed(input logic [31:0] ins, output int tries);
    bit adv = 0;
    tries = 0;
    while (!adv && tries < 4) begin
      cycle(ins, 1'b1, 1'b0, adv);
      tries++;
    end
    if (!adv) begin
      checks++;
      failures++;
      $error("FAIL fetch_timeout instr=%0h tries=%0d", ins, tries);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] f7  = 7'($urandom);
    logic [4:0] rs2 = 5'($urandom_range(0, 3));
    logic [4:0] rs1 = 5'($urandom_range(0, 3));
    logic [4:0] rd  = 5'($urandom_range(0, 3));
    logic [2:0] f3  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd2;
    logic [6:0] op;
    if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
    case ($urandom_range(0, 5))
      0: op = 7'h03;
      1: op = 7'h23;
      2: begin
        op = 7'h33;
        f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
        f3 = 3'($urandom);
      end
      3: op = 7'h13;
      4: return 32'($urandom);
      default: return 32'h0;
    endcase
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  initial begin
    bit          adv;
    int          tries;
    logic [31:0] cur;

    // Reset held for two edges; state is unknown before then.
    reset  = 1'b1;
    dhit   = 1'b1;
    instrD = I_ZERO;
    repeat (2) @(posedge clk);
    w_e = '0; w_m = '0; w_w = '0;
    #1;
    cycle(I_ZERO, 1'b1, 1'b1, adv);
    chk("reset_pc_en", 32'(pc_en), 32'd0);

    // LW x5,4(x1): E one edge later, W three edges later.
    feed(I_LW, tries);
    chk("lw_alusrc_e", 32'(ALUSrcE), 32'd1);
    feed(I_ZERO, tries);
    feed(I_ZERO, tries);
    chk("lw_regwrite_w", 32'(RegWriteW), 32'd1);
    chk("lw_memtoreg_w", 32'(MemtoRegW), 32'd1);
    repeat (2) feed(I_ZERO, tries);

    // SB x2,0(x3): single-cycle store strobe, no register write.
    feed(I_SB, tries);
    repeat (4) feed(I_ZERO, tries);

    // SW reaches M, then memory stalls for three cycles.
    feed(I_SW, tries);
    feed(I_ZERO, tries);
    chk("sw_strobe_m", 32'(MemWriteM), 32'd1);
    repeat (3) cycle(I_LW, 1'b0, 1'b0, adv);
    chk("sw_strobe_held", 32'(MemWriteM), 32'd1);
    cycle(I_LW, 1'b1, 1'b0, adv);
    chk("sw_strobe_released", 32'(MemWriteM), 32'd0);
    repeat (3) feed(I_ZERO, tries);

    // Load-use pair: one bubble with the interlock, none without.
    feed(I_LW, tries);
    feed(I_ADD, tries);
    chk("ld_use_attempts", 32'(tries), INTERLOCK ? 32'd2 : 32'd1);
    repeat (4) feed(I_ZERO, tries);

    // Illegal encoding and a write to x0 never write anything.
    feed(I_ZERO, tries);
    feed(I_ADDI, tries);
    repeat (4) feed(I_ZERO, tries);

    // Reset mid-flight discards everything, including during a stall.
    feed(I_LW, tries);
    feed(I_SW, tries);
    cycle(I_ZERO, 1'b0, 1'b1, adv);
    chk("midreset_memwrite", 32'(MemWriteM), 32'd0);
    chk("midreset_alusrc",   32'(ALUSrcE),   32'd0);
    repeat (3) feed(I_ZERO, tries);

    // Randomized traffic with memory stalls and occasional resets.
    cur = rand_instr();
    for (int i = 0; i < 600; i++) begin
      cycle(cur,
            ($urandom_range(0, 5) != 0),
            ($urandom_range(0, 60) == 0),
            adv);
      if (adv) cur = rand_instr();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- instrD  in  32  instruction currently in the decode stage
- dhit  in  1  memory ready; 0 freezes the whole pipeline
- pc_en  out  1  fetch advance enable
- LoadD  out  1  decode-stage immediate select: 1 = I-type, 0 = S-type
- ByteD  out  1  decode-stage byte-store select
- ALUSrcE  out  1  execute B-operand select: 1 = immediate
- AluControlE  out  3  execute ALU operation
- MemWriteM  out  1  memory-stage store strobe
- RegWriteW  out  1  writeback register-file write enable
- MemtoRegW  out  1  writeback result select: 1 = memory data
- ByteW  out  1  writeback byte-load select
- bubbleE  out  1  1 = execute-stage register loads a NOP
REQ-002 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL decode instrD[6:0] / funct3 [14:12] / funct7 [31:25] combinationally:
- 0000011 LW (f3 010), LB (f3 000): load, imm, ADD, RegWrite, MemtoReg; LB sets Byte.
- 0100011 SW (f3 010), SB (f3 000): store, imm, ADD, MemWrite; SB sets Byte.
- 0110011 ADD / SUB / AND / OR / XOR / SLT: reg-reg ALU op, RegWrite.
- 0010011 ADDI: imm, ADD, RegWrite.
REQ-004 SHALL treat any other encoding, or rd = 0 for register writes, as NOP: RegWrite = 0, MemWrite = 0.
REQ-005 SHALL drive LoadD = 1 for loads and I-type ALU instructions, 0 otherwise.
REQ-006 SHALL drive ByteD combinationally from the decode of instrD.
REQ-007 SHALL carry the control bundle through registers D->E->M->W. Each stage adds exactly 1 cycle, so a decoded instruction's RegWriteW appears 3 enabled edges after decode.
REQ-008 SHALL hold every pipeline register when dhit = 0, and SHALL drive pc_en = 0 in that case.
REQ-009 SHALL leave MemWriteM unchanged while dhit = 0, so the store strobe persists until dhit returns.
REQ-010 SHALL track destination register rd [11:7] in E, M and W alongside the control bits.
REQ-011 SHALL treat a stall as simultaneous with reset by letting reset win: registers clear even when dhit = 0.
REQ-012 SHALL keep pc_en combinational: dhit AND NOT interlock stall AND NOT reset.

Reset
REQ-013 SHALL clear all E/M/W control registers and tracked rd fields to 0 on a clk edge with reset = 1. The resulting state is equivalent to NOPs in every stage.
REQ-014 SHALL drive these outputs during and after reset until the first decode: pc_en = 0 while reset = 1; ALUSrcE = 0; AluControlE = 000; MemWriteM = 0; RegWriteW = 0; MemtoRegW = 0; ByteW = 0; bubbleE = 0.
REQ-015 SHALL discard in-flight instructions on reset mid-operation; no partial write is issued.

Configuration
REQ-016 With macro PIPE_CTRL_INTERLOCK_EN defined, SHALL detect load-use hazards. Condition: E holds a load AND rdE != 0 AND rdE equals instrD[19:15] or instrD[24:20].
- On the hazard: pc_en = 0, D is held, bubbleE = 1, a NOP is loaded into E.
- The stall lasts exactly 1 enabled cycle.
REQ-017 Without PIPE_CTRL_INTERLOCK_EN, SHALL tie bubbleE to 0 and never stall for hazards; software scheduling is responsible.

Structure
REQ-018 SHALL place in shared package pipe_pkg:
- opcode constants OP_LOAD, OP_STORE, OP_R, OP_I;
- ALU encoding alu_op_t: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101;
- packed struct ctrl_t for the control bundle.
REQ-019 SHALL isolate decoding in one combinational sub-module, ctrl_decode (instrD -> ctrl_t). pipe_ctrl contains only the stage registers and the interlock.

Verification
REQ-020 SHALL be covered by these directed scenarios:
- Reset: hold reset 2 cycles with dhit = 1 -> all outputs 0, pc_en = 0; release -> pc_en = 1 the next cycle.
- LW x5,4(x1) decoded with dhit = 1 -> LoadD = 1, ALUSrcE = 1 and AluControlE = 000 one cycle later, MemtoRegW = 1 and RegWriteW = 1 three cycles later.
- SB x2,0(x3) -> ByteD = 1 at decode; MemWriteM = 1 for exactly one cycle; RegWriteW never 1.
- Stall: SW issued, dhit = 0 for 3 cycles at M -> MemWriteM held 1 throughout, pc_en = 0, all stages frozen, resume on dhit = 1.
- With PIPE_CTRL_INTERLOCK_EN: LW x5 followed by ADD x6,x5,x7 -> bubbleE = 1 and pc_en = 0 for 1 cycle; ADD's RegWriteW lands 1 cycle later than unstalled. Without the macro -> no bubble.
- Illegal opcode 0x00000000 and ADDI x0,x0,1 -> RegWriteW = 0 and MemWriteM = 0 in every stage.
